// File: rtl/decim_filt.sv
// ---------------------------------------------------------------------------
// decim_filt -- fifth-order sinc (CIC) decimator for the record path.
//
// Takes samples from the ADC deserialiser, applies a (1 + z^-1 + ... +
// z^-(R-1))^5 response and returns every R-th result. R = 2^DECIM_LOG2.
// The output is divided by R^5 (floor), so the DC gain is exactly 1.
//
// Ports:
//   clk        single system clock, rising edge
//   rst        synchronous reset, active-high
//   in_valid   x carries a new sample this cycle (may be high every cycle)
//   x          signed input sample, WIDTH bits
//   out_valid  one-cycle strobe: y holds a new decimated sample
//   y          signed output sample, WIDTH bits, held between strobes
//
// Timing: out_valid rises 7 clocks after the group-completing in_valid is
// sampled, whatever the spacing of in_valid.
// ---------------------------------------------------------------------------
module decim_filt #(
  parameter int WIDTH      = 16,
  parameter int DECIM_LOG2 = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  output logic             out_valid,
  output logic [WIDTH-1:0] y
);

  localparam int SHIFT = 5 * DECIM_LOG2;
  localparam int IW    = WIDTH + SHIFT;
  localparam int NSTG  = 5;

  // Integrator and comb arithmetic wraps modulo 2^IW on purpose; the comb
  // differences undo the wrap exactly, so no saturation anywhere.
  logic [IW-1:0] x_ext;
  assign x_ext = {{SHIFT{x[WIDTH-1]}}, x};

  // -------------------------------------------------------------------------
  // Input-rate section: integrators, phase counter, capture register
  // -------------------------------------------------------------------------
  logic [NSTG-1:0][IW-1:0] integ_q, integ_d;
  logic [DECIM_LOG2-1:0]   phase_q, phase_d;
  logic                    group_done;
  logic                    pend_q, pend_d;
  logic [IW-1:0]           cap_q, cap_d;
  logic                    cap_valid_q, cap_valid_d;

  always_comb begin
    integ_d     = integ_q;
    phase_d     = phase_q;
    group_done  = in_valid && (phase_q == {DECIM_LOG2{1'b1}});
    if (in_valid) begin
      integ_d[0] = integ_q[0] + x_ext;
      // Each stage adds the previous stage's old value (pipelined cascade).
      for (int k = 1; k < NSTG; k++) begin
        integ_d[k] = integ_q[k] + integ_q[k-1];
      end
      phase_d = phase_q + DECIM_LOG2'(1);
    end
    // The capture happens one edge after the completing sample, so it takes
    // the i5 value that edge produced even if a new sample arrives meanwhile.
    pend_d      = group_done;
    cap_valid_d = pend_q;
    cap_d       = pend_q ? integ_q[NSTG-1] : cap_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      integ_q     <= '0;
      phase_q     <= '0;
      pend_q      <= 1'b0;
      cap_q       <= '0;
      cap_valid_q <= 1'b0;
    end else begin
      integ_q     <= integ_d;
      phase_q     <= phase_d;
      pend_q      <= pend_d;
      cap_q       <= cap_d;
      cap_valid_q <= cap_valid_d;
    end
  end

  // -------------------------------------------------------------------------
  // Decimated-rate comb chain: five differentiators, one clock per stage.
  // Stage gi reads stg_data/stg_valid[gi] and drives index gi+1.
  // -------------------------------------------------------------------------
  logic [NSTG:0][IW-1:0] stg_data;
  logic [NSTG:0]         stg_valid;

  assign stg_data[0]  = cap_q;
  assign stg_valid[0] = cap_valid_q;

  for (genvar gi = 0; gi < NSTG; gi++) begin : g_comb
    logic [IW-1:0] c_q, c_d;
    logic [IW-1:0] d_q, d_d;
    logic          v_q, v_d;

    always_comb begin
      c_d = c_q;
      d_d = d_q;
      v_d = stg_valid[gi];
      if (stg_valid[gi]) begin
        c_d = stg_data[gi] - d_q;
        d_d = stg_data[gi];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        c_q <= '0;
        d_q <= '0;
        v_q <= 1'b0;
      end else begin
        c_q <= c_d;
        d_q <= d_d;
        v_q <= v_d;
      end
    end

    assign stg_data[gi+1]  = c_q;
    assign stg_valid[gi+1] = v_q;
  end

  // -------------------------------------------------------------------------
  // Output: divide by R^5 with an arithmetic shift (floor toward -inf).
  // The result always fits WIDTH bits because the response is a weighted
  // average of inputs with non-negative weights.
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] y_q, y_d;
  logic             ov_q, ov_d;

  always_comb begin
    ov_d = stg_valid[NSTG];
    y_d  = y_q;
    if (stg_valid[NSTG]) begin
      y_d = WIDTH'($signed(stg_data[NSTG]) >>> SHIFT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q  <= '0;
      ov_q <= 1'b0;
    end else begin
      y_q  <= y_d;
      ov_q <= ov_d;
    end
  end

  assign y         = y_q;
  assign out_valid = ov_q;

endmodule

// File: tb/tb_decim_filt.sv
// ---------------------------------------------------------------------------
// tb_decim_filt -- bench for decim_filt. Two instances (R=2 and R=4) share
// one input stream. Expected outputs come from a direct convolution with
// the box-filter^5 coefficients followed by floor division by R^5; expected
// output times come from the edge on which each completing sample was taken.
// ---------------------------------------------------------------------------
module tb_decim_filt;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] x = '0;
  logic         ov1, ov2;
  logic [W-1:0] y1, y2;

  decim_filt #(.WIDTH(W), .DECIM_LOG2(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x(x),
    .out_valid(ov1), .y(y1)
  );

  decim_filt #(.WIDTH(W), .DECIM_LOG2(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x(x),
    .out_valid(ov2), .y(y2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  // Accepted samples since the last reset, and the edge each was taken on.
  int acc_x[$];
  int acc_edge[$];
  // Observed outputs per instance and the edge that raised out_valid.
  int o1_y[$], o1_e[$], o2_y[$], o2_e[$];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(negedge clk) begin
    if (ov1) begin
      o1_y.push_back(int'($signed(y1)));
      o1_e.push_back(edge_cnt);
    end
    if (ov2) begin
      o2_y.push_back(int'($signed(y2)));
      o2_e.push_back(edge_cnt);
    end
  end

  // Reference: output m = floor( sum_k h[k] * x[m*R+R-1-4-k] / R^5 ).
  function automatic int model_y(input int lg, input int m);
    int     r;
    int     n;
    longint h[$];
    longint t[$];
    longint s;
    longint d;
    longint q;
    r = 1 << lg;
    h.push_back(1);
    repeat (5) begin
      t = {};
      for (int i = 0; i < h.size() + r - 1; i++) begin
        longint a = 0;
        for (int j = 0; j < r; j++)
          if (i - j >= 0 && i - j < h.size()) a += h[i-j];
        t.push_back(a);
      end
      h = t;
    end
    n = m * r + r - 1 - 4;
    s = 0;
    for (int k = 0; k < h.size(); k++) begin
      int idx = n - k;
      if (idx >= 0 && idx < acc_x.size()) s += h[k] * longint'(acc_x[idx]);
    end
    d = longint'(r) ** 5;
    q = s / d;
    if ((s % d) != 0 && s < 0) q -= 1;
    return int'(q);
  endfunction

  task automatic clear_q();
    acc_x = {}; acc_edge = {};
    o1_y = {}; o1_e = {}; o2_y = {}; o2_e = {};
  endtask

  // One clock: present (v, xv) for the next rising edge.
  task automatic step(input bit v, input int xv);
    @(posedge clk);
    #1;
    in_valid = v;
    x = xv[W-1:0];
    if (v) begin
      acc_x.push_back(xv);
      acc_edge.push_back(edge_cnt + 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0);
  endtask

  // Reset with a live sample on the input: it must be dropped.
  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; in_valid = 1'b1; x = 16'h7777;
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0; x = '0;
    clear_q();
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) begin
      in_valid = 1'b1; x = W'($urandom);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL reset_ov1 got %b exp 0", ov1); end
    checks++; if (y1 !== '0) begin errors++; $display("FAIL reset_y1 got %0d exp 0", y1); end
    checks++; if (ov2 !== 1'b0) begin errors++; $display("FAIL reset_ov2 got %b exp 0", ov2); end
    checks++; if (y2 !== '0) begin errors++; $display("FAIL reset_y2 got %0d exp 0", y2); end
    $display("reset: ov1=%b y1=%0d ov2=%b y2=%0d", ov1, y1, ov2, y2);
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0; x = '0;
    clear_q();
  endtask

  task automatic test_impulse();
    int exp1[6] = '{0, 0, 500, 1000, 100, 0};
    apply_reset();
    step(1'b1, 3200);
    repeat (23) step(1'b1, 0);
    idle(12);
    checks++;
    if (o1_y.size() !== 12) begin errors++; $display("FAIL impulse_count1 got %0d exp 12", o1_y.size()); end
    for (int m = 0; m < 6 && m < o1_y.size(); m++) begin
      checks++;
      if (o1_y[m] !== exp1[m]) begin errors++; $display("FAIL impulse_y1[%0d] got %0d exp %0d", m, o1_y[m], exp1[m]); end
      $display("impulse R=2 out %0d: y=%0d edge=%0d", m, o1_y[m], o1_e[m]);
    end
    for (int d = 1; d <= 2; d++) begin
      int ys[$]; int es[$]; int r;
      r = 1 << d;
      if (d == 1) begin ys = o1_y; es = o1_e; end else begin ys = o2_y; es = o2_e; end
      checks++;
      if (ys.size() !== acc_x.size() / r) begin errors++; $display("FAIL impulse_cnt L=%0d got %0d exp %0d", d, ys.size(), acc_x.size() / r); end
      for (int m = 0; m < ys.size() && m < acc_x.size() / r; m++) begin
        checks++;
        if (ys[m] !== model_y(d, m)) begin errors++; $display("FAIL impulse_model L=%0d m=%0d got %0d exp %0d", d, m, ys[m], model_y(d, m)); end
        checks++;
        if (es[m] !== acc_edge[m*r+r-1] + 7) begin errors++; $display("FAIL impulse_lat L=%0d m=%0d got %0d exp %0d", d, m, es[m], acc_edge[m*r+r-1] + 7); end
      end
    end
  endtask

  task automatic test_rounding();
    int expp[6] = '{0, 0, 5, 10, 1, 0};
    int expn[6] = '{0, 0, -6, -11, -2, 0};
    for (int pass = 0; pass < 2; pass++) begin
      apply_reset();
      step(1'b1, (pass == 0) ? 33 : -33);
      repeat (15) step(1'b1, 0);
      idle(12);
      checks++;
      if (o1_y.size() !== 8) begin errors++; $display("FAIL round_count pass=%0d got %0d exp 8", pass, o1_y.size()); end
      for (int m = 0; m < 6 && m < o1_y.size(); m++) begin
        int e;
        e = (pass == 0) ? expp[m] : expn[m];
        checks++;
        if (o1_y[m] !== e) begin errors++; $display("FAIL round_y pass=%0d m=%0d got %0d exp %0d", pass, m, o1_y[m], e); end
        $display("rounding pass %0d out %0d: y=%0d", pass, m, o1_y[m]);
      end
    end
  endtask

  task automatic test_full_scale();
    apply_reset();
    repeat (3000) step(1'b1, 32767);
    repeat (3000) step(1'b1, -32768);
    idle(12);
    checks++;
    if (o1_y.size() < 3000 || o1_y[1499] !== 32767 || o1_y[2999] !== -32768) begin
      errors++;
      $display("FAIL fullscale_settle1 got n=%0d %0d %0d exp 32767 -32768", o1_y.size(),
               (o1_y.size() > 1499) ? o1_y[1499] : 0, (o1_y.size() > 2999) ? o1_y[2999] : 0);
    end
    checks++;
    if (o2_y.size() < 1500 || o2_y[749] !== 32767 || o2_y[1499] !== -32768) begin
      errors++;
      $display("FAIL fullscale_settle2 got n=%0d %0d %0d exp 32767 -32768", o2_y.size(),
               (o2_y.size() > 749) ? o2_y[749] : 0, (o2_y.size() > 1499) ? o2_y[1499] : 0);
    end
    $display("fullscale: R=2 outputs=%0d R=4 outputs=%0d", o1_y.size(), o2_y.size());
    for (int d = 1; d <= 2; d++) begin
      int ys[$]; int r;
      r = 1 << d;
      if (d == 1) ys = o1_y; else ys = o2_y;
      checks++;
      if (ys.size() !== acc_x.size() / r) begin errors++; $display("FAIL fullscale_cnt L=%0d got %0d exp %0d", d, ys.size(), acc_x.size() / r); end
      for (int m = 0; m < ys.size() && m < acc_x.size() / r; m++) begin
        checks++;
        if (ys[m] !== model_y(d, m)) begin errors++; $display("FAIL fullscale_model L=%0d m=%0d got %0d exp %0d", d, m, ys[m], model_y(d, m)); end
      end
    end
  endtask

  task automatic test_gapped();
    apply_reset();
    for (int n = 0; n < 40; n++) begin
      step(1'b1, n * 10);
      step(1'b0, 0);
      step(1'b0, 0);
    end
    idle(12);
    checks++;
    if (o1_y.size() !== 20) begin errors++; $display("FAIL gapped_count got %0d exp 20", o1_y.size()); end
    for (int d = 1; d <= 2; d++) begin
      int ys[$]; int es[$]; int r;
      r = 1 << d;
      if (d == 1) begin ys = o1_y; es = o1_e; end else begin ys = o2_y; es = o2_e; end
      checks++;
      if (ys.size() !== acc_x.size() / r) begin errors++; $display("FAIL gapped_cnt L=%0d got %0d exp %0d", d, ys.size(), acc_x.size() / r); end
      for (int m = 0; m < ys.size() && m < acc_x.size() / r; m++) begin
        checks++;
        if (ys[m] !== model_y(d, m)) begin errors++; $display("FAIL gapped_model L=%0d m=%0d got %0d exp %0d", d, m, ys[m], model_y(d, m)); end
        checks++;
        if (es[m] !== acc_edge[m*r+r-1] + 7) begin errors++; $display("FAIL gapped_lat L=%0d m=%0d got %0d exp %0d", d, m, es[m], acc_edge[m*r+r-1] + 7); end
        if (d == 1) $display("gapped R=2 out %0d: y=%0d edge=%0d", m, ys[m], es[m]);
      end
    end
  endtask

  task automatic test_mid_reset();
    int e0;
    int late1;
    int late2;
    int exp1[5] = '{0, 0, 500, 1000, 100};
    apply_reset();
    for (int n = 0; n < 10; n++) step(1'b1, int'($urandom_range(1000, 20000)));
    e0 = acc_edge[9];
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++; if (ov1 !== 1'b0 || y1 !== '0) begin errors++; $display("FAIL midrst_dut1 got ov=%b y=%0d exp 0 0", ov1, y1); end
    checks++; if (ov2 !== 1'b0 || y2 !== '0) begin errors++; $display("FAIL midrst_dut2 got ov=%b y=%0d exp 0 0", ov2, y2); end
    idle(12);
    late1 = 0; late2 = 0;
    foreach (o1_e[i]) if (o1_e[i] >= e0 + 3) late1++;
    foreach (o2_e[i]) if (o2_e[i] >= e0 + 3) late2++;
    checks++; if (late1 !== 0) begin errors++; $display("FAIL midrst_flush1 got %0d exp 0", late1); end
    checks++; if (late2 !== 0) begin errors++; $display("FAIL midrst_flush2 got %0d exp 0", late2); end
    $display("midreset: completing edge=%0d late outputs=%0d/%0d", e0, late1, late2);
    clear_q();
    step(1'b1, 3200);
    repeat (11) step(1'b1, 0);
    idle(12);
    checks++;
    if (o1_y.size() !== 6) begin errors++; $display("FAIL midrst_count got %0d exp 6", o1_y.size()); end
    for (int m = 0; m < 5 && m < o1_y.size(); m++) begin
      checks++;
      if (o1_y[m] !== exp1[m]) begin errors++; $display("FAIL midrst_y[%0d] got %0d exp %0d", m, o1_y[m], exp1[m]); end
      checks++;
      if (o1_e[m] !== acc_edge[2*m+1] + 7) begin errors++; $display("FAIL midrst_lat[%0d] got %0d exp %0d", m, o1_e[m], acc_edge[2*m+1] + 7); end
      $display("midreset impulse out %0d: y=%0d", m, o1_y[m]);
    end
  endtask

  task automatic test_r4();
    int exp2[6] = '{0, 35, 155, 65, 1, 0};
    apply_reset();
    step(1'b1, 1024);
    repeat (27) step(1'b1, 0);
    idle(12);
    checks++;
    if (o2_y.size() !== 7) begin errors++; $display("FAIL r4_imp_count got %0d exp 7", o2_y.size()); end
    for (int m = 0; m < 6 && m < o2_y.size(); m++) begin
      checks++;
      if (o2_y[m] !== exp2[m]) begin errors++; $display("FAIL r4_imp_y[%0d] got %0d exp %0d", m, o2_y[m], exp2[m]); end
      $display("impulse R=4 out %0d: y=%0d", m, o2_y[m]);
    end
    apply_reset();
    repeat (120) step(1'b1, -1234);
    idle(12);
    checks++;
    if (o2_y.size() !== 30 || o2_y[29] !== -1234) begin
      errors++;
      $display("FAIL r4_dc got n=%0d last=%0d exp 30 -1234", o2_y.size(), (o2_y.size() > 0) ? o2_y[o2_y.size()-1] : 0);
    end
    for (int m = 4; m < o2_y.size(); m++) begin
      checks++;
      if (o2_y[m] !== -1234) begin errors++; $display("FAIL r4_dc_settle m=%0d got %0d exp -1234", m, o2_y[m]); end
    end
    $display("dc R=4: outputs=%0d", o2_y.size());
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) != 0) step(1'b1, int'($signed(W'($urandom))));
      else step(1'b0, 0);
    end
    idle(12);
    for (int d = 1; d <= 2; d++) begin
      int ys[$]; int es[$]; int r;
      r = 1 << d;
      if (d == 1) begin ys = o1_y; es = o1_e; end else begin ys = o2_y; es = o2_e; end
      checks++;
      if (ys.size() !== acc_x.size() / r) begin errors++; $display("FAIL random_cnt L=%0d got %0d exp %0d", d, ys.size(), acc_x.size() / r); end
      for (int m = 0; m < ys.size() && m < acc_x.size() / r; m++) begin
        checks++;
        if (ys[m] !== model_y(d, m)) begin errors++; $display("FAIL random_model L=%0d m=%0d got %0d exp %0d", d, m, ys[m], model_y(d, m)); end
        checks++;
        if (es[m] !== acc_edge[m*r+r-1] + 7) begin errors++; $display("FAIL random_lat L=%0d m=%0d got %0d exp %0d", d, m, es[m], acc_edge[m*r+r-1] + 7); end
      end
      $display("random L=%0d: samples=%0d outputs=%0d", d, acc_x.size(), ys.size());
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_rounding();
    test_full_scale();
    test_gapped();
    test_mid_reset();
    test_r4();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
